// File: rtl/joystick_debouncer_if.sv
// joystick_debouncer_if
//   Groups the raw button pins and the conditioned paddle controls of the
//   joystick debouncer.
//   master : drives the raw buttons, observes the conditioned outputs
//   slave  : the debouncer (reads the buttons, drives the outputs)
//   Signals:
//     btn_up_n, btn_down_n     raw active-low buttons (asynchronous to clock)
//     control_up, control_down debounced, conflict-resolved levels (active-low)
//     up_press, down_press     one-cycle active-high press pulses
interface joystick_debouncer_if;
   logic btn_up_n;
   logic btn_down_n;
   logic control_up;
   logic control_down;
   logic up_press;
   logic down_press;

   modport master (
      output btn_up_n,
      output btn_down_n,
      input  control_up,
      input  control_down,
      input  up_press,
      input  down_press
   );

   modport slave (
      input  btn_up_n,
      input  btn_down_n,
      output control_up,
      output control_down,
      output up_press,
      output down_press
   );
endinterface

// File: rtl/joystick_debouncer.sv
// joystick_debouncer
//   Turns the two raw joystick buttons into clean control levels for the
//   paddle. Each channel is synchronized (two flops), debounced by a
//   stability counter, then both channels pass through a registered
//   conflict-resolution stage that also produces press pulses.
//   Ports:
//     clock  system clock, everything on its rising edge
//     reset  synchronous active-high reset
//     js     joystick_debouncer_if.slave: raw buttons in, controls/pulses out
//   Parameters:
//     DEBOUNCE_CYCLES  consecutive mismatching clocks needed to accept a level
//     CNT_WIDTH        width of each stability counter
module joystick_debouncer #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_WIDTH       = 18
) (
   input  logic                 clock,
   input  logic                 reset,
   joystick_debouncer_if.slave  js
);

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   // Channel 0 = up, channel 1 = down.
   logic [1:0] raw_n;
   logic [1:0] deb;

   assign raw_n = {js.btn_down_n, js.btn_up_n};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_chan
         logic                 sync1_reg;
         logic                 sync2_reg;
         logic                 deb_reg;
         logic [CNT_WIDTH-1:0] cnt_reg;

         always_ff @(posedge clock) begin
            if (reset) begin
               sync1_reg <= 1'b1;
               sync2_reg <= 1'b1;
               deb_reg   <= 1'b1;
               cnt_reg   <= '0;
            end else begin
               sync1_reg <= raw_n[gi];
               sync2_reg <= sync1_reg;
               // Any cycle where the synchronized level agrees with the
               // accepted state restarts the window, so bounces never
               // accumulate toward acceptance.
               if (sync2_reg == deb_reg) begin
                  cnt_reg <= '0;
               end else if (cnt_reg == CNT_LAST) begin
                  deb_reg <= sync2_reg;
                  cnt_reg <= '0;
               end else begin
                  cnt_reg <= cnt_reg + CNT_WIDTH'(1);
               end
            end
         end

         assign deb[gi] = deb_reg;
      end
   endgenerate

   // Output stage: previous debounced pair for edge detection, resolved
   // control levels and press pulses, all registered.
   logic [1:0] deb_prev_reg;
   logic [1:0] control_reg;
   logic [1:0] press_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         deb_prev_reg <= 2'b11;
         control_reg  <= 2'b11;
         press_reg    <= 2'b00;
      end else begin
         deb_prev_reg <= deb;
         // Both pressed at once means no direction wins: release both.
         control_reg  <= (deb == 2'b00) ? 2'b11 : deb;
         // Pulses follow the raw debounced falling edges, independent of
         // the conflict rule, so a masked press is still reported.
         press_reg    <= ~deb & deb_prev_reg;
      end
   end

   assign js.control_up   = control_reg[0];
   assign js.control_down = control_reg[1];
   assign js.up_press     = press_reg[0];
   assign js.down_press   = press_reg[1];

endmodule

// File: tb/tb_joystick_debouncer.sv
module tb_joystick_debouncer;

   localparam int DEB = 4;
   localparam int LAT = DEB + 2;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int unsigned cyc = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   joystick_debouncer_if jif ();

   joystick_debouncer #(
      .DEBOUNCE_CYCLES(DEB),
      .CNT_WIDTH(4)
   ) dut (
      .clock(clock),
      .reset(reset),
      .js(jif.slave)
   );

   // {control_up, control_down, up_press, down_press}
   logic [3:0] outs;
   assign outs = {jif.control_up, jif.control_down, jif.up_press, jif.down_press};

   typedef struct {
      string       name;
      int unsigned cyc;
      logic [3:0]  vec;
   } exp_t;

   exp_t exp_q[$];
   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;

   task automatic check_vec(input string name, input logic [3:0] act, input logic [3:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, req);
      end else
         $display("ok   %s: %b", name, act);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic expect_ev(input string name, input int unsigned c, input logic [3:0] v);
      exp_t e;
      e.name = name;
      e.cyc  = c;
      e.vec  = v;
      exp_q.push_back(e);
   endtask

   // Monitor: every change on the outputs must match the next expected event,
   // both in value and in the edge at which it appeared.
   initial begin : monitor
      logic [3:0] prev;
      exp_t e;
      wait (mon_en);
      prev = outs;
      forever begin
         @(negedge clock);
         if (outs !== prev) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_change: got %b at edge %0d expected no change", outs, cyc);
            end else begin
               e = exp_q.pop_front();
               if (outs !== e.vec || cyc != e.cyc) begin
                  errors++;
                  $display("FAIL %s: got %b at edge %0d expected %b at edge %0d",
                           e.name, outs, cyc, e.vec, e.cyc);
               end else
                  $display("ok   %s: %b at edge %0d", e.name, outs, cyc);
            end
            prev = outs;
         end
      end
   end

   initial begin : stimulus
      int unsigned t0;
      jif.btn_up_n   = 1'b0;
      jif.btn_down_n = 1'b1;

      // Reset held with up pressed: outputs stay idle.
      for (int i = 0; i < 3; i++) begin
         step(1);
         check_vec("reset_idle", outs, 4'b1100);
      end
      reset = 1'b0;
      t0 = cyc + 1;
      mon_en = 1'b1;
      expect_ev("held_through_reset_press", t0 + LAT, 4'b0110);
      expect_ev("held_through_reset_pulse_end", t0 + LAT + 1, 4'b0100);
      step(LAT + 4);
      jif.btn_up_n = 1'b1;
      t0 = cyc + 1;
      expect_ev("reset_release", t0 + LAT, 4'b1100);
      step(LAT + 4);

      // Clean press and release of up.
      jif.btn_up_n = 1'b0;
      t0 = cyc + 1;
      expect_ev("clean_press", t0 + LAT, 4'b0110);
      expect_ev("clean_pulse_end", t0 + LAT + 1, 4'b0100);
      step(LAT + 4);
      jif.btn_up_n = 1'b1;
      t0 = cyc + 1;
      expect_ev("clean_release", t0 + LAT, 4'b1100);
      step(LAT + 4);

      // Bounce on down: 3 low, 1 high, then low.
      jif.btn_down_n = 1'b0;
      step(3);
      jif.btn_down_n = 1'b1;
      step(1);
      jif.btn_down_n = 1'b0;
      t0 = cyc + 1;
      expect_ev("bounce_press", t0 + LAT, 4'b1001);
      expect_ev("bounce_pulse_end", t0 + LAT + 1, 4'b1000);
      step(LAT + 4);
      jif.btn_down_n = 1'b1;
      t0 = cyc + 1;
      expect_ev("bounce_release", t0 + LAT, 4'b1100);
      step(LAT + 4);

      // Conflict: up held, then down pressed, then up released.
      jif.btn_up_n = 1'b0;
      t0 = cyc + 1;
      expect_ev("conflict_up_press", t0 + LAT, 4'b0110);
      expect_ev("conflict_up_pulse_end", t0 + LAT + 1, 4'b0100);
      step(LAT + 4);
      jif.btn_down_n = 1'b0;
      t0 = cyc + 1;
      expect_ev("conflict_both_masked", t0 + LAT, 4'b1101);
      expect_ev("conflict_down_pulse_end", t0 + LAT + 1, 4'b1100);
      step(LAT + 4);
      jif.btn_up_n = 1'b1;
      t0 = cyc + 1;
      expect_ev("conflict_down_takes_over", t0 + LAT, 4'b1000);
      step(LAT + 4);
      jif.btn_down_n = 1'b1;
      t0 = cyc + 1;
      expect_ev("conflict_down_release", t0 + LAT, 4'b1100);
      step(LAT + 4);

      // Reset mid-count: reset sampled at edge 3 of the qualification.
      jif.btn_up_n = 1'b0;
      step(2);
      reset = 1'b1;
      step(1);
      check_vec("midcount_reset_idle", outs, 4'b1100);
      reset = 1'b0;
      t0 = cyc + 1;
      expect_ev("midcount_requalified", t0 + LAT, 4'b0110);
      expect_ev("midcount_pulse_end", t0 + LAT + 1, 4'b0100);
      step(LAT + 4);
      jif.btn_up_n = 1'b1;
      t0 = cyc + 1;
      expect_ev("midcount_release", t0 + LAT, 4'b1100);
      step(LAT + 4);

      // Glitch: one-cycle low must be rejected.
      jif.btn_up_n = 1'b0;
      step(1);
      jif.btn_up_n = 1'b1;
      step(LAT + 6);
      check_vec("glitch_rejected", outs, 4'b1100);

      // Every expected event must have been observed.
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_events: got %0d unseen expected 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
